// File: rtl/ascon_arbiter.sv
// ---------------------------------------------------------------------------
// ascon_arbiter
// Round-robin scheduler that shares one ascon encryption core between N_REQ
// requesters. One requester owns the core for a whole message: the arbiter
// registers its key/nonce, pulses the core start, paces the data blocks into
// the core, and routes cipher blocks and the final tag back to the owner. A
// watchdog releases the core if it stalls while a response is awaited.
//
// Ports
//   clock, reset          : single rising-edge clock, synchronous active-high reset
//   i_sys_enable          : global hold; when low all state/counters/outputs hold
//   i_req[N]              : per-requester message request (level, sampled in IDLE)
//   i_req_key/nonce[N*128]: per-requester key/nonce, slice k = [128k+127:128k]
//   i_req_data[N*64]      : per-requester data block
//   i_req_data_valid[N]   : data block valid
//   o_req_data_ready[N]   : data block accepted when valid & ready
//   o_grant[N]            : one-hot owner of the core, zero when idle
//   o_req_cipher, o_req_cipher_valid[N] : cipher bus + pulse to the owner
//   o_req_tag, o_req_done[N]            : tag bus + done pulse to the owner
//   o_error               : watchdog pulse
//   o_core_*              : start/data/key/nonce towards the core
//   i_core_*              : cipher/tag/valid/done from the core
// ---------------------------------------------------------------------------
module ascon_arbiter #(
    parameter int N_REQ          = 4,
    parameter int BLOCKS_PER_MSG = 4,
    parameter int AD_WAIT_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_sys_enable,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*128-1:0] i_req_key,
    input  logic [N_REQ*128-1:0] i_req_nonce,
    input  logic [N_REQ*64-1:0]  i_req_data,
    input  logic [N_REQ-1:0]     i_req_data_valid,
    output logic [N_REQ-1:0]     o_req_data_ready,
    output logic [N_REQ-1:0]     o_grant,
    output logic [63:0]          o_req_cipher,
    output logic [N_REQ-1:0]     o_req_cipher_valid,
    output logic [127:0]         o_req_tag,
    output logic [N_REQ-1:0]     o_req_done,
    output logic                 o_error,
    output logic                 o_core_start,
    output logic                 o_core_data_valid,
    output logic [63:0]          o_core_data,
    output logic [127:0]         o_core_key,
    output logic [127:0]         o_core_nonce,
    input  logic [63:0]          i_core_cipher,
    input  logic [127:0]         i_core_tag,
    input  logic                 i_core_valid_cipher,
    input  logic                 i_core_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BLK_W = (BLOCKS_PER_MSG > 1) ? $clog2(BLOCKS_PER_MSG) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLOCKS_PER_MSG - 1);
    localparam logic [7:0]       AD_LAST  = 8'(AD_WAIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_FEED      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [N_REQ-1:0]   r_grant;
    logic [BLK_W-1:0]   r_blk;
    logic [7:0]         r_ad_cnt;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_core_start;
    logic               r_core_dv;
    logic [N_REQ-1:0]   r_cipher_valid;
    logic [N_REQ-1:0]   r_done;
    logic               r_error;
    logic [63:0]        r_core_data;
    logic [127:0]       r_core_key;
    logic [127:0]       r_core_nonce;
    logic [63:0]        r_req_cipher;
    logic [127:0]       r_req_tag;

    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_found;
    logic               w_transfer;

    // Saturating watchdog increment.
    function automatic logic [WD_W-1:0] wd_inc(input logic [WD_W-1:0] v);
        return (v == {WD_W{1'b1}}) ? v : v + WD_W'(1);
    endfunction

    // Round-robin pick: scan from farthest to nearest after rr_ptr so the
    // nearest requesting index is the one left standing.
    always_comb begin
        w_win_idx   = r_rr_ptr;
        w_win_found = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_win_idx   = i_req[IDX_W'((int'(r_rr_ptr) + i) % N_REQ)]
                          ? IDX_W'((int'(r_rr_ptr) + i) % N_REQ) : w_win_idx;
            w_win_found = w_win_found | i_req[IDX_W'((int'(r_rr_ptr) + i) % N_REQ)];
        end
    end

    // Ready is offered only to the owner, and only when the FSM can advance.
    assign o_req_data_ready = (r_state == ST_FEED && i_sys_enable) ? r_grant : {N_REQ{1'b0}};
    assign w_transfer       = |(i_req_data_valid & o_req_data_ready);

    // Pulse registers hold while disabled; gating the outputs with the enable
    // makes a pending pulse appear once, in the first enabled cycle.
    assign o_core_start       = r_core_start & i_sys_enable;
    assign o_core_data_valid  = r_core_dv & i_sys_enable;
    assign o_req_cipher_valid = r_cipher_valid & {N_REQ{i_sys_enable}};
    assign o_req_done         = r_done & {N_REQ{i_sys_enable}};
    assign o_error            = r_error & i_sys_enable;
    assign o_grant            = r_grant;
    assign o_core_data        = r_core_data;
    assign o_core_key         = r_core_key;
    assign o_core_nonce       = r_core_nonce;
    assign o_req_cipher       = r_req_cipher;
    assign o_req_tag          = r_req_tag;

    // Message FSM with its counters and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= IDX_W'(N_REQ - 1);
            r_owner        <= '0;
            r_grant        <= '0;
            r_blk          <= '0;
            r_ad_cnt       <= 8'd0;
            r_wd_cnt       <= '0;
            r_core_start   <= 1'b0;
            r_core_dv      <= 1'b0;
            r_cipher_valid <= '0;
            r_done         <= '0;
            r_error        <= 1'b0;
            r_core_data    <= 64'd0;
            r_core_key     <= 128'd0;
            r_core_nonce   <= 128'd0;
            r_req_cipher   <= 64'd0;
            r_req_tag      <= 128'd0;
        end else if (i_sys_enable) begin
            r_core_start   <= 1'b0;
            r_core_dv      <= 1'b0;
            r_cipher_valid <= '0;
            r_done         <= '0;
            r_error        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_found) begin
                        r_grant      <= ONE_HOT0 << w_win_idx;
                        r_owner      <= w_win_idx;
                        r_rr_ptr     <= w_win_idx;
                        r_core_key   <= i_req_key[int'(w_win_idx)*128 +: 128];
                        r_core_nonce <= i_req_nonce[int'(w_win_idx)*128 +: 128];
                        r_core_start <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_blk   <= '0;
                    r_state <= ST_FEED;
                end
                ST_FEED: begin
                    if (w_transfer) begin
                        r_core_data <= i_req_data[int'(r_owner)*64 +: 64];
                        r_core_dv   <= 1'b1;
                        r_ad_cnt    <= 8'd0;
                        r_wd_cnt    <= '0;
                        r_state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (r_blk == '0) begin
                        // Associated data gets no cipher back; pace it by time.
                        if (r_ad_cnt == AD_LAST) begin
                            r_wd_cnt <= '0;
                            if (r_blk == LAST_BLK) begin
                                r_state <= ST_WAIT_DONE;
                            end else begin
                                r_blk   <= r_blk + BLK_W'(1);
                                r_state <= ST_FEED;
                            end
                        end else begin
                            r_ad_cnt <= r_ad_cnt + 8'd1;
                        end
                    end else if (i_core_valid_cipher) begin
                        r_req_cipher   <= i_core_cipher;
                        r_cipher_valid <= r_grant;
                        r_wd_cnt       <= '0;
                        if (r_blk == LAST_BLK) begin
                            r_state <= ST_WAIT_DONE;
                        end else begin
                            r_blk   <= r_blk + BLK_W'(1);
                            r_state <= ST_FEED;
                        end
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_error <= 1'b1;
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd_cnt <= wd_inc(r_wd_cnt);
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_core_done) begin
                        r_req_tag <= i_core_tag;
                        r_done    <= r_grant;
                        r_grant   <= '0;
                        r_state   <= ST_IDLE;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_error <= 1'b1;
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd_cnt <= wd_inc(r_wd_cnt);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ascon_arbiter
// Directed sequence of messages with random keys, nonces, data, ciphers and
// tags. A small message-level reference (round-robin owner choice, expected
// latencies, expected pulse counts per message) predicts every observation.
// ---------------------------------------------------------------------------
module tb_ascon_arbiter;

    localparam int N   = 4;
    localparam int BPM = 4;
    localparam int ADW = 8;
    localparam int TO  = 1024;

    logic             clock = 1'b0;
    logic             reset;
    logic             i_sys_enable;
    logic [N-1:0]     i_req;
    logic [N*128-1:0] i_req_key;
    logic [N*128-1:0] i_req_nonce;
    logic [N*64-1:0]  i_req_data;
    logic [N-1:0]     i_req_data_valid;
    logic [N-1:0]     o_req_data_ready;
    logic [N-1:0]     o_grant;
    logic [63:0]      o_req_cipher;
    logic [N-1:0]     o_req_cipher_valid;
    logic [127:0]     o_req_tag;
    logic [N-1:0]     o_req_done;
    logic             o_error;
    logic             o_core_start;
    logic             o_core_data_valid;
    logic [63:0]      o_core_data;
    logic [127:0]     o_core_key;
    logic [127:0]     o_core_nonce;
    logic [63:0]      i_core_cipher;
    logic [127:0]     i_core_tag;
    logic             i_core_valid_cipher;
    logic             i_core_done;

    always #5 clock = ~clock;

    ascon_arbiter #(
        .N_REQ(N), .BLOCKS_PER_MSG(BPM), .AD_WAIT_CYCLES(ADW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .i_sys_enable(i_sys_enable),
        .i_req(i_req), .i_req_key(i_req_key), .i_req_nonce(i_req_nonce),
        .i_req_data(i_req_data), .i_req_data_valid(i_req_data_valid),
        .o_req_data_ready(o_req_data_ready), .o_grant(o_grant),
        .o_req_cipher(o_req_cipher), .o_req_cipher_valid(o_req_cipher_valid),
        .o_req_tag(o_req_tag), .o_req_done(o_req_done), .o_error(o_error),
        .o_core_start(o_core_start), .o_core_data_valid(o_core_data_valid),
        .o_core_data(o_core_data), .o_core_key(o_core_key), .o_core_nonce(o_core_nonce),
        .i_core_cipher(i_core_cipher), .i_core_tag(i_core_tag),
        .i_core_valid_cipher(i_core_valid_cipher), .i_core_done(i_core_done)
    );

    int checks = 0;
    int errors = 0;
    int rr_last = N - 1;
    logic [127:0] keys [N];
    logic [127:0] nonces [N];

    // Pulse counters, sampled mid-cycle.
    int n_start = 0;
    int n_dv = 0;
    int n_cv = 0;
    always @(negedge clock) begin
        if (o_core_start) n_start++;
        if (o_core_data_valid) n_dv++;
        if (|o_req_cipher_valid) n_cv++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_owner(input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(rr_last + i) % N]) return (rr_last + i) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_last = N - 1;
    endtask

    // mode 0: normal, 1: core silent after block 1, 2: reset in WAIT_DONE
    task automatic run_msg(input int mode, input int slow, input bit stall,
                           input bit spur_done, input bit drop_req, input logic [127:0] tag);
        int own;
        int n;
        int s0;
        int dv0;
        int cv0;
        logic [N-1:0] oh;
        logic [63:0] d;
        logic [63:0] c;
        own = next_owner(i_req);
        if (own < 0) begin
            chk("owner_exists", 128'd0, 128'd1);
            return;
        end
        oh = N'(1) << own;
        rr_last = own;
        s0 = n_start; dv0 = n_dv; cv0 = n_cv;
        tick();
        chk("grant", o_grant, oh);
        chk("start", o_core_start, 1);
        chk("key", o_core_key, keys[own]);
        chk("nonce", o_core_nonce, nonces[own]);
        tick();
        chk("start_once", o_core_start, 0);
        if (spur_done) begin
            i_core_done = 1'b1;
            tick();
            i_core_done = 1'b0;
            chk("spur_grant", o_grant, oh);
            chk("spur_done", o_req_done, 0);
        end
        for (int b = 0; b < BPM; b++) begin
            if (slow > 0 && b == 1) begin
                for (int s = 0; s < slow; s++) begin
                    tick();
                    chk("slow_nodv", o_core_data_valid, 0);
                end
            end
            d = {$urandom, $urandom};
            i_req_data[own*64 +: 64] = d;
            i_req_data_valid = oh;
            chk("ready", o_req_data_ready, oh);
            tick();
            i_req_data_valid = '0;
            chk("dv", o_core_data_valid, 1);
            chk("data", o_core_data, d);
            if (b == 0) begin
                n = 0;
                while (o_req_data_ready == '0 && n < 64) begin
                    if (stall && n == 2) i_sys_enable = 1'b0;
                    if (stall && n == 7) i_sys_enable = 1'b1;
                    tick();
                    n++;
                end
                chk("ad_gap", n, stall ? ADW + 5 : ADW);
            end else begin
                if (drop_req && b == 1) i_req = '0;
                if (mode == 1 && b == 1) begin
                    n = 0;
                    while (!o_error && n < TO + 50) begin
                        tick();
                        n++;
                    end
                    chk("wd_time", n, TO);
                    chk("wd_grant", o_grant, 0);
                    chk("wd_nodone", o_req_done, 0);
                    return;
                end
                repeat (6) tick();
                c = {$urandom, $urandom};
                i_core_cipher = c;
                i_core_valid_cipher = 1'b1;
                tick();
                i_core_valid_cipher = 1'b0;
                chk("cv", o_req_cipher_valid, oh);
                chk("cipher", o_req_cipher, c);
            end
        end
        tick();
        tick();
        if (mode == 2) begin
            do_reset();
            chk("rst_grant", o_grant, 0);
            chk("rst_done", o_req_done, 0);
            chk("rst_error", o_error, 0);
            chk("rst_key", o_core_key, 0);
            chk("rst_data", o_core_data, 0);
            chk("rst_cipher", o_req_cipher, 0);
            return;
        end
        i_core_tag = tag;
        i_core_done = 1'b1;
        tick();
        i_core_done = 1'b0;
        chk("done", o_req_done, oh);
        chk("tag", o_req_tag, tag);
        chk("grant_clr", o_grant, 0);
        chk("n_start", n_start - s0, 1);
        chk("n_dv", n_dv - dv0, BPM);
        chk("n_cv", n_cv - cv0, BPM - 1);
    endtask

    initial begin
        reset = 1'b1;
        i_sys_enable = 1'b1;
        i_req = '0;
        i_req_data = '0;
        i_req_data_valid = '0;
        i_core_cipher = 64'd0;
        i_core_tag = 128'd0;
        i_core_valid_cipher = 1'b0;
        i_core_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            keys[k]   = {$urandom, $urandom, $urandom, $urandom};
            nonces[k] = {$urandom, $urandom, $urandom, $urandom};
            i_req_key[k*128 +: 128]   = keys[k];
            i_req_nonce[k*128 +: 128] = nonces[k];
        end
        tick();
        do_reset();
        chk("reset_grant", o_grant, 0);
        chk("reset_start", o_core_start, 0);
        chk("reset_ready", o_req_data_ready, 0);
        chk("reset_key", o_core_key, 0);
        chk("reset_tag", o_req_tag, 0);

        // Single requester 2 with a fixed tag.
        i_req = 4'b0100;
        run_msg(0, 0, 1'b0, 1'b0, 1'b0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
        i_req = '0;
        tick();

        // Fairness from reset: expected owners 0,1,2,3,0.
        do_reset();
        i_req = 4'b1111;
        run_msg(0, 0, 1'b0, 1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        run_msg(0, 20, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        run_msg(0, 0, 1'b1, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        run_msg(0, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        run_msg(0, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        // Watchdog, then the next requester is served.
        run_msg(1, 0, 1'b0, 1'b0, 1'b0, 128'd0);
        run_msg(0, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        // Reset during WAIT_DONE, then requester 0 wins again.
        run_msg(2, 0, 1'b0, 1'b0, 1'b0, 128'd0);
        run_msg(0, 0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        // Request dropped mid-message still completes; core stays idle afterwards.
        i_req = 4'b1000;
        run_msg(0, 0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        repeat (3) tick();
        chk("idle_grant", o_grant, 0);
        chk("idle_start", o_core_start, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_arbiter.md
# ascon_arbiter

Round-robin scheduler sharing one `ascon` encryption core between `N_REQ` requesters. It grants the core to one requester per message, issues the core start pulse, and paces data blocks into the core. It routes cipher blocks and the final tag back to the granted requester, and recovers from a stalled core with a watchdog.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BLOCKS_PER_MSG`, 4: blocks per message. Block 0 is associated data; blocks 1..`BLOCKS_PER_MSG`-1 are plaintext.
- `AD_WAIT_CYCLES`, 8: cycles waited after the block-0 pulse before the next block is fed. Range 1..255.
- `TIMEOUT_CYCLES`, 1024: watchdog limit while waiting on the core.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_sys_enable` in 1: when low, all state, counters and outputs hold.
- `i_req` in N_REQ: per-requester message request, level.
- `i_req_key` in N_REQ*128: per-requester key. Slice k is bits [128k+127:128k].
- `i_req_nonce` in N_REQ*128: per-requester nonce, same slicing as the key.
- `i_req_data` in N_REQ*64: per-requester data block.
- `i_req_data_valid` in N_REQ: data block valid.
- `o_req_data_ready` out N_REQ: data block accepted when both valid and ready are high.
- `o_grant` out N_REQ: one-hot owner of the core; all zero when idle.
- `o_req_cipher` out 64: shared cipher bus.
- `o_req_cipher_valid` out N_REQ: one-cycle pulse to the owner.
- `o_req_tag` out 128: shared tag bus.
- `o_req_done` out N_REQ: one-cycle pulse to the owner; the tag is valid in that cycle.
- `o_error` out 1: one-cycle watchdog pulse.
- `o_core_start` out 1: one-cycle pulse to the core.
- `o_core_data_valid` out 1: one-cycle pulse to the core, one per block.
- `o_core_data` out 64: block data, held from the pulse until the next transfer.
- `o_core_key` out 128: registered key, held for the whole message.
- `o_core_nonce` out 128: registered nonce, held for the whole message.
- `i_core_cipher` in 64: core cipher output.
- `i_core_tag` in 128: core tag output.
- `i_core_valid_cipher` in 1: core cipher-valid pulse.
- `i_core_done` in 1: core done pulse.

## Operation
- States: IDLE, START, FEED, WAIT_ACK, WAIT_DONE.
- **IDLE:** if any `i_req` is high, pick the first requesting index after `rr_ptr` (wrapping). Register the grant and key/nonce, set `rr_ptr` to the winner, go to START.
- **START:** `o_core_start`=1 for exactly one cycle. Clear the block counter and go to FEED.
- **FEED:** `o_req_data_ready`[owner]=1 combinationally; it is 0 for every other requester.
  - On a transfer, latch the data into `o_core_data`.
  - Pulse `o_core_data_valid` on the next cycle and go to WAIT_ACK.
- **WAIT_ACK, block 0:** count `AD_WAIT_CYCLES`, then return to FEED; ignore `i_core_valid_cipher`.
- **WAIT_ACK, block ≥1:** wait for `i_core_valid_cipher`.
  - Copy `i_core_cipher` to `o_req_cipher` and pulse `o_req_cipher_valid`[owner].
  - Increment the block counter.
  - Go to FEED, or to WAIT_DONE after block `BLOCKS_PER_MSG`-1.
- **WAIT_DONE:** on `i_core_done`, register `i_core_tag` into `o_req_tag` and pulse `o_req_done`[owner]. Clear `o_grant` and go to IDLE.
- **Request level:** `i_req` is only sampled in IDLE. Deasserting it mid-message does not abort; the message completes.
- **Watchdog:** the counter runs in WAIT_ACK (block ≥1) and WAIT_DONE, and clears on each state entry. When it reaches `TIMEOUT_CYCLES`, pulse `o_error`, clear the grant and go to IDLE. `rr_ptr` still advances.
- **Spurious core pulses:** `i_core_valid_cipher` or `i_core_done` outside their wait state is ignored.
- **Counter widths:** the block counter is sized for `BLOCKS_PER_MSG`-1. The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

## Timing
- **Reset:** state IDLE; every output 0; `rr_ptr`=`N_REQ`-1, so requester 0 wins first.
- **Reset mid-message:** same as reset; no done or error pulse.
- **Grant latency:** `i_req` sampled high at edge t → `o_grant` and `o_core_start` high in cycle t+1 → FEED from t+2.
- **Data latency:** transfer in cycle c → `o_core_data_valid` in cycle c+1 → WAIT_ACK from c+1.
- **Block 0 gap:** FEED re-entered `AD_WAIT_CYCLES` cycles after the `o_core_data_valid` pulse.
- **Cipher forwarding:** `i_core_valid_cipher` in cycle c → `o_req_cipher_valid` in c+1, with the cipher on the bus.
- **Done forwarding:** `i_core_done` in cycle c → `o_req_done` in c+1 → IDLE in c+1. A new grant is possible at c+2, so there is a one-cycle minimum gap between messages.
- **Enable low:** with `i_sys_enable` low, pulses do not fire and counters do not advance. A pulse due that cycle is deferred, not dropped.

## Test plan
- **Single requester:** N_REQ=4; only req2 high; 4 blocks; core responds with a cipher 6 cycles after each data pulse. Expect:
  - `o_grant`=4'b0100 one cycle after the request;
  - one `o_core_start`;
  - 4 `o_core_data_valid` pulses with data matching the stimulus;
  - 3 `o_req_cipher_valid`[2] pulses;
  - `o_req_done`[2] carrying tag 128'hDEAD…BEEF.
- **Round-robin fairness:** all 4 requesting continuously; expect grant order 0,1,2,3,0 across 5 messages.
- **Slow requester:** owner holds `i_req_data_valid` low for 20 cycles in FEED. Expect no `o_core_data_valid` during that time, the watchdog not counting, and completion afterwards.
- **Watchdog:** core never pulses `i_core_valid_cipher` after block 1. Expect `o_error` at exactly 1024 cycles after WAIT_ACK entry, grant cleared, and the next requester served.
- **Mid-message reset and enable stall:** assert `reset` during WAIT_DONE → all outputs 0 next cycle, req0 wins next. Separately, drop `i_sys_enable` for 5 cycles during WAIT_ACK block 0 → the 8-cycle wait stretches to 13.
- **Spurious and late core pulses:** a `i_core_done` pulse in FEED is ignored. A request deassert in WAIT_ACK still produces all remaining ciphers and `o_req_done`.
